// File: rtl/dualmem_pkg.sv
// Shared constants and types for the dual-port memory stream reader.
package dualmem_pkg;

    localparam int AW_DEF     = 13;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dualmem_reader_fifo.sv
// Small synchronous FIFO holding {last, data} entries between the memory port and the byte stream.
module rdr_fifo
    import dualmem_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic [FIFO_CW-1:0] count,
    output logic               empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] slots [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FIFO_CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + FIFO_CW'(1);
                2'b01:   count <= count - FIFO_CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/dualmem_reader.sv
// Streaming read engine: turns an (address, length) command into single-cycle memory reads
// and returns the bytes in order on a valid/ready stream with a last flag.
module dualmem_reader
    import dualmem_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
    // its payload steady while valid is high and ready is low, and valid never waits on ready.

    state_t               state_q;
    logic [AW-1:0]        rd_addr;
    logic [AW:0]          rem_issue;
    logic [AW:0]          rem_out;
    logic                 inflight;
    logic                 inflight_last;
    logic [FIFO_CW-1:0]   fifo_cnt;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    logic [FIFO_CW:0]     occupancy;
    logic                 issue;
    logic                 pop;

    // Slots already promised (stored + the read whose data lands next cycle) gate new reads,
    // so the FIFO cannot overflow and out_ready never reaches mem_en.
    assign occupancy = {1'b0, fifo_cnt} + {{FIFO_CW{1'b0}}, inflight};
    assign issue     = (state_q == READ) && (rem_issue != '0)
                       && (occupancy < (FIFO_CW + 1)'(FIFO_DEPTH));

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_din   = 8'h00;
    assign mem_addr  = rd_addr;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_head[7:0];
    assign out_last  = !fifo_empty && fifo_head[8];
    assign pop       = out_valid && out_ready;

    rdr_fifo u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight),
        .din   ({inflight_last, mem_dout}),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rd_addr       <= '0;
            rem_issue     <= '0;
            rem_out       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (rem_issue == (AW + 1)'(1));
            if (pop) rem_out <= rem_out - (AW + 1)'(1);

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_addr   <= cmd_addr;
                        rem_issue <= cmd_len;
                        rem_out   <= cmd_len;
                        if (cmd_len == '0) done <= 1'b1;
                        else               state_q <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr   <= rd_addr + AW'(1);
                        rem_issue <= rem_issue - (AW + 1)'(1);
                        if (rem_issue == (AW + 1)'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // rem_out reaching its final byte coincides with the FIFO entry tagged last.
                    if (pop && (rem_out == (AW + 1)'(1))) begin
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dualmem_reader.sv
// Self-checking bench for dualmem_reader with a behavioural dual-port memory and a byte scoreboard.
module tb_dualmem_reader;

    localparam int AW    = 13;
    localparam int MEM_N = 1 << AW;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [7:0]    mem [MEM_N];
    logic [8:0]    exp_q [$];
    logic [AW-1:0] addr_log [$];

    int total = 0;
    int bad   = 0;

    int st_first_en, st_first_valid, st_last_hs, st_done_cyc;
    int st_n_en, st_n_hs, st_n_done, st_max_out, st_we_bad;

    dualmem_reader #(.AW(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read port of the shared memory: one-cycle latency.
    initial mem_dout = 8'h00;
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic       stall_q;
        logic [7:0] stall_data;
        logic       stall_last;
        logic [8:0] e;
        stall_q    = 1'b0;
        stall_data = 8'h00;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    total++;
                    if (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last) begin
                        bad++;
                        $display("FAIL stall_hold got=%0b/%02h/%0b want=1/%02h/%0b",
                                 out_valid, out_data, out_last, stall_data, stall_last);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected got=%0b/%02h want=no_byte", out_last, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_last, out_data} !== e) begin
                            bad++;
                            $display("FAIL sb_byte got=%0b/%02h want=%0b/%02h",
                                     out_last, out_data, e[8], e[7:0]);
                        end
                    end
                end
                stall_q    = out_valid && !out_ready;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [AW-1:0] addr, input logic [AW:0] len);
        logic [8:0] e;
        for (int i = 0; i < int'(len); i++) begin
            e[8]   = (i == int'(len) - 1);
            e[7:0] = mem[(int'(addr) + i) % MEM_N];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input logic [AW:0] len, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                push_expect(addr, len);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge; stops two cycles after done.
    task automatic wait_done(input int mode, input int budget);
        st_first_en = -1; st_first_valid = -1; st_last_hs = -1; st_done_cyc = -1;
        st_n_en = 0; st_n_hs = 0; st_n_done = 0; st_max_out = 0; st_we_bad = 0;
        addr_log.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (mem_en) begin
                st_n_en++;
                addr_log.push_back(mem_addr);
                if (st_first_en < 0) st_first_en = c;
            end
            if (mem_we !== 1'b0 || mem_din !== 8'h00) st_we_bad++;
            if (st_n_en - st_n_hs > st_max_out) st_max_out = st_n_en - st_n_hs;
            if (out_valid && st_first_valid < 0) st_first_valid = c;
            if (out_valid && out_ready) begin
                st_n_hs++;
                st_last_hs = c;
            end
            if (done) begin
                st_n_done++;
                if (st_done_cyc < 0) st_done_cyc = c;
            end
            if (st_done_cyc >= 0 && c >= st_done_cyc + 2) break;
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        out_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b want=1", cmd_ready); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%0b want=0", mem_en); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%02h want=00", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    endtask

    task automatic test_basic();
        bit ok;
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'(8'h10 + i);
        send_cmd(13'h0100, 14'd8, ok);
        wait_done(0, 40);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_accept got=%0b want=1", ok); end
        total++; if (st_first_en != 1) begin bad++; $display("FAIL basic_first_en got=%0d want=1", st_first_en); end
        total++; if (st_first_valid != 3) begin bad++; $display("FAIL basic_first_valid got=%0d want=3", st_first_valid); end
        total++; if (st_n_hs != 8) begin bad++; $display("FAIL basic_bytes got=%0d want=8", st_n_hs); end
        total++; if (st_last_hs != 10) begin bad++; $display("FAIL basic_last_cycle got=%0d want=10", st_last_hs); end
        total++; if (st_done_cyc != 11) begin bad++; $display("FAIL basic_done_cycle got=%0d want=11", st_done_cyc); end
        total++; if (st_n_done != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", st_n_done); end
        total++; if (st_we_bad != 0) begin bad++; $display("FAIL basic_write_port got=%0d want=0", st_we_bad); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        send_cmd(13'h0100, 14'd8, ok);
        wait_done(1, 60);
        total++; if (st_n_hs != 8) begin bad++; $display("FAIL stall_bytes got=%0d want=8", st_n_hs); end
        total++; if (st_max_out > 4) begin bad++; $display("FAIL stall_occupancy got=%0d want<=4", st_max_out); end
        total++; if (st_done_cyc != st_last_hs + 1 || st_done_cyc < 0) begin bad++; $display("FAIL stall_done_cycle got=%0d want=%0d", st_done_cyc, st_last_hs + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [AW-1:0] want [4];
        want[0] = 13'h1FFE; want[1] = 13'h1FFF; want[2] = 13'h0000; want[3] = 13'h0001;
        send_cmd(13'h1FFE, 14'd4, ok);
        wait_done(0, 30);
        total++; if (addr_log.size() != 4) begin bad++; $display("FAIL wrap_reads got=%0d want=4", addr_log.size()); end
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            total++;
            if (addr_log[i] !== want[i]) begin bad++; $display("FAIL wrap_addr%0d got=%04h want=%04h", i, addr_log[i], want[i]); end
        end
        total++; if (st_n_hs != 4) begin bad++; $display("FAIL wrap_bytes got=%0d want=4", st_n_hs); end
    endtask

    task automatic test_len_zero();
        bit ok;
        send_cmd(13'h0040, 14'd0, ok);
        wait_done(0, 10);
        total++; if (st_n_en != 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", st_n_en); end
        total++; if (st_first_valid != -1) begin bad++; $display("FAIL zero_out_valid got=%0d want=-1", st_first_valid); end
        total++; if (st_done_cyc != 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", st_done_cyc); end
        total++; if (st_n_done != 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", st_n_done); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        send_cmd(13'h0200, 14'd16, ok);
        repeat (6) @(posedge clk);
        #1 rstn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_out_valid got=%0b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mreset_busy got=%0b want=0", busy); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mreset_cmd_ready got=%0b want=1", cmd_ready); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL mreset_mem_en got=%0b want=0", mem_en); end
        send_cmd(13'h0300, 14'd2, ok);
        wait_done(0, 20);
        total++; if (st_n_hs != 2) begin bad++; $display("FAIL mreset_bytes got=%0d want=2", st_n_hs); end
        total++; if (st_n_done != 1) begin bad++; $display("FAIL mreset_done got=%0d want=1", st_n_done); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mreset_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit acc;
        bit acc_with_done;
        int n_hs, n_done, fin;
        int last_pos [$];
        send_cmd(13'h0400, 14'd3, ok);
        #0;
        cmd_valid = 1'b1; cmd_addr = 13'h0500; cmd_len = 14'd2;
        acc = 1'b0; acc_with_done = 1'b0; n_hs = 0; n_done = 0; fin = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_hs++;
                if (out_last) last_pos.push_back(n_hs);
            end
            if (done) n_done++;
            if (!acc && cmd_ready) begin
                acc = 1'b1;
                acc_with_done = done;
                push_expect(13'h0500, 14'd2);
            end
            if (n_done == 2 && fin < 0) fin = c;
            if (fin >= 0 && c >= fin + 2) break;
            @(posedge clk); #1;
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        total++; if (acc_with_done !== 1'b1) begin bad++; $display("FAIL b2b_accept_on_done got=%0b want=1", acc_with_done); end
        total++; if (n_hs != 5) begin bad++; $display("FAIL b2b_bytes got=%0d want=5", n_hs); end
        total++; if (n_done != 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", n_done); end
        total++;
        if (last_pos.size() != 2 || last_pos[0] != 3 || last_pos[1] != 5) begin
            bad++;
            $display("FAIL b2b_last_pos got=%p want='{3,5}", last_pos);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        logic [AW-1:0] addr;
        logic [AW:0]   len;
        for (int n = 0; n < 6; n++) begin
            addr = AW'($urandom_range(0, MEM_N - 1));
            len  = (AW + 1)'($urandom_range(1, 24));
            send_cmd(addr, len, ok);
            wait_done(2, 300);
            total++; if (st_n_hs != int'(len)) begin bad++; $display("FAIL rand%0d_bytes got=%0d want=%0d", n, st_n_hs, len); end
            total++; if (st_n_done != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", n, st_n_done); end
            total++; if (st_max_out > 4) begin bad++; $display("FAIL rand%0d_occupancy got=%0d want<=4", n, st_max_out); end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
        for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_zero();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
